// File: rtl/adc_i2c_pkg.sv
// Shared types and constants for the ADC I2C target and the matching master block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_i2c_pkg;

  // Target FSM states; the master block reuses the bus constants below.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic [6:0] ADC_DEV_ADDR = 7'b0101000;
  localparam logic [1:0] ADC_RD_HDR   = 2'b00;
  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;

  // Two-byte read word as the converter presents it: header, channel, 12-bit result.
  function automatic logic [15:0] adc_rd_word(input logic [1:0] channel,
                                              input logic [11:0] data);
    return {ADC_RD_HDR, channel, data};
  endfunction

endpackage

// File: rtl/adc_i2c_target_if.sv
// Pin and sample-source bundle for the ADC I2C target.
// Latency: n/a (wiring only).
// Backpressure: n/a; the target side never stalls the bus or the sample source.
interface adc_i2c_target_if;

  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [11:0] sample_data;
  logic [1:0]  sample_channel;
  logic        sample_req;
  logic [7:0]  config_reg;
  logic        config_wr;
  logic        busy;

  // Target view: pads and sample source in, SDA drive and status out.
  modport slave (
    input  scl_in, sda_in, sample_data, sample_channel,
    output sda_oe, sample_req, config_reg, config_wr, busy
  );

  // Bus master / sample source view.
  modport master (
    output scl_in, sda_in, sample_data, sample_channel,
    input  sda_oe, sample_req, config_reg, config_wr, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES clk from pad to sda_s; edge/condition strobes one-clk wide at that point.
// Backpressure: none; free-running sampler.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_s;

  // Synchronizer chains plus one history flop per line. They keep sampling
  // through reset so that, once reset lifts, the history reflects the real bus
  // and a mid-transfer data bit cannot be mistaken for a START.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    scl_hist <= scl_sync[SYNC_STAGES-1];
    sda_hist <= sda_sync[SYNC_STAGES-1];
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  // SDA transitions are only legal with SCL low, so any SDA edge seen while
  // SCL is high on both samples is a bus condition.
  assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/adc_i2c_target.sv
// I2C target emulating the board ADC: config byte on writes, 12-bit samples on reads.
// Latency: SDA drive registered 1 clk after the synchronized SCL fall (SYNC_STAGES+1 clk from pad).
// Backpressure: none; no clock stretching, sample source read only in the sample_req cycle.
module adc_i2c_target
  import adc_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = ADC_DEV_ADDR,
  parameter logic [7:0] CONF_RST    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  adc_i2c_target_if.slave  bus
);

  logic scl_rise;
  logic scl_fall;
  logic sda_s;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;     // bits seen in the current byte, wraps at the boundary
  logic [6:0]     shift;       // first seven bits of an incoming byte
  logic           rw;          // R/W bit of the last matched address
  logic           ack_held;    // ACK phases: first fall already handled
  logic [15:0]    tx;          // latched read word
  logic           byte_idx;    // 0 = high byte of tx, 1 = low byte
  logic           sda_oe;
  logic           sample_req;
  logic           config_wr;
  logic [7:0]     config_reg;
  logic           busy;

  logic [7:0]     rx_byte;
  logic [7:0]     cur_byte;
  logic [15:0]    new_tx;

  // Byte completed by the bit being sampled right now.
  assign rx_byte  = {shift, sda_s};
  assign cur_byte = byte_idx ? tx[7:0] : tx[15:8];
  assign new_tx   = adc_rd_word(bus.sample_channel, bus.sample_data);

  // Target protocol FSM; START/STOP override any bit-level activity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      rw         <= 1'b0;
      ack_held   <= 1'b0;
      tx         <= 16'd0;
      byte_idx   <= 1'b0;
      sda_oe     <= 1'b0;
      sample_req <= 1'b0;
      config_wr  <= 1'b0;
      config_reg <= CONF_RST;
      busy       <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      config_wr  <= 1'b0;
      if (start_det) begin
        // Plain or repeated START: always restart address reception.
        state    <= ADDR;
        bit_cnt  <= 3'd0;
        ack_held <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        ack_held <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw <= sda_s;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state    <= ADDR_ACK;
                  ack_held <= 1'b0;
                end else begin
                  // Someone else's transfer: stay off the bus until STOP/START.
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_held) begin
                sda_oe   <= ~I2C_ACK;
                ack_held <= 1'b1;
              end else begin
                ack_held <= 1'b0;
                bit_cnt  <= 3'd0;
                if (!rw) begin
                  sda_oe <= 1'b0;
                  state  <= WR_BYTE;
                end else begin
                  // Latch the sample here and put its MSB on the line at once.
                  tx         <= new_tx;
                  sample_req <= 1'b1;
                  byte_idx   <= 1'b0;
                  sda_oe     <= ~new_tx[15];
                  state      <= RD_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                config_reg <= rx_byte;
                config_wr  <= 1'b1;
                state      <= WR_ACK;
                ack_held   <= 1'b0;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_held) begin
                sda_oe   <= ~I2C_ACK;
                ack_held <= 1'b1;
              end else begin
                ack_held <= 1'b0;
                sda_oe   <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= WR_BYTE;
              end
            end
          end

          RD_BYTE: begin
            // bit_cnt counts bits the master has sampled; it is back at zero
            // on the fall that follows the eighth bit.
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe   <= 1'b0;
                ack_held <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sda_oe <= ~cur_byte[3'd7 - bit_cnt];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise && !ack_held) begin
              if (sda_s == I2C_ACK) begin
                ack_held <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end else if (scl_fall && ack_held) begin
              ack_held <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= RD_BYTE;
              if (byte_idx) begin
                // Low byte acknowledged: continuous read of a fresh sample.
                tx         <= new_tx;
                sample_req <= 1'b1;
                byte_idx   <= 1'b0;
                sda_oe     <= ~new_tx[15];
              end else begin
                byte_idx <= 1'b1;
                sda_oe   <= ~tx[7];
              end
            end
          end

          IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe;
  assign bus.sample_req = sample_req;
  assign bus.config_wr  = config_wr;
  assign bus.config_reg = config_reg;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_adc_i2c_target.sv
// Bench for adc_i2c_target: bit-banged I2C master with an open-drain SDA model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst;
  logic scl_m;
  logic sda_m;
  logic sda_line;

  always #5 clk = ~clk;

  adc_i2c_target_if bus_if ();

  assign sda_line      = sda_m & ~bus_if.sda_oe;
  assign bus_if.scl_in = scl_m;
  assign bus_if.sda_in = sda_line;

  adc_i2c_target #(
    .DEV_ADDR    (7'b0101000),
    .CONF_RST    (8'h00),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int sreq_cnt = 0;
  int cfg_cnt = 0;
  int oe_cycles = 0;
  int sda_viol = 0;
  logic prev_scl = 1'b0;
  logic prev_oe = 1'b0;
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_cfg_q[$];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, config scoreboard and SDA-stable-while-SCL-high watch.
  always @(negedge clk) begin
    if (bus_if.sample_req === 1'b1) sreq_cnt <= sreq_cnt + 1;
    if (bus_if.sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;
    if (scl_m && prev_scl && (bus_if.sda_oe !== prev_oe)) sda_viol <= sda_viol + 1;
    if (bus_if.config_wr === 1'b1) begin
      cfg_cnt <= cfg_cnt + 1;
      check_eq("cfg_wr_expected", 16'(exp_cfg_q.size() != 0), 16'd1);
      if (exp_cfg_q.size() != 0) check_eq("config_reg", 16'(bus_if.config_reg), 16'(exp_cfg_q.pop_front()));
    end
    prev_scl <= scl_m;
    prev_oe  <= bus_if.sda_oe;
  end

  function automatic logic [15:0] adc_word(input logic [1:0] ch, input logic [11:0] d);
    return {2'b00, ch, d};
  endfunction

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(2);
    sda_m = 1'b0; wait_q(2);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b1; wait_q(2);
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q(1);
    scl_m = 1'b1; wait_q(2);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    acked = ~sda_line;
    wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic read_bits(input int n, output logic [7:0] bits);
    bits = 8'h00;
    for (int i = 0; i < n; i++) begin
      sda_m = 1'b1; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      bits = {bits[6:0], sda_line};
      wait_q(1);
      scl_m = 1'b0; wait_q(1);
    end
  endtask

  task automatic read_and_check(input logic ack_bit, input string tag);
    logic [7:0] got;
    read_bits(8, got);
    send_bit(ack_bit);
    check_eq({tag, "_q_nonempty"}, 16'(exp_rd_q.size() != 0), 16'd1);
    if (exp_rd_q.size() != 0) check_eq(tag, 16'(got), 16'(exp_rd_q.pop_front()));
  endtask

  task automatic push_read(input logic [1:0] ch, input logic [11:0] d);
    logic [15:0] w;
    w = adc_word(ch, d);
    exp_rd_q.push_back(w[15:8]);
    exp_rd_q.push_back(w[7:0]);
  endtask

  initial begin
    logic       ack;
    logic [7:0] bits;
    int         s0;
    int         c0;
    int         o0;

    rst = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    bus_if.sample_data = 12'h000;
    bus_if.sample_channel = 2'b00;

    // Reset state
    repeat (5) @(negedge clk);
    check_eq("rst_sda_oe", 16'(bus_if.sda_oe), 16'd0);
    check_eq("rst_busy", 16'(bus_if.busy), 16'd0);
    check_eq("rst_config_reg", 16'(bus_if.config_reg), 16'h00);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_busy", 16'(bus_if.busy), 16'd0);
    check_eq("idle_sda_oe", 16'(bus_if.sda_oe), 16'd0);
    check_eq("idle_sreq_cnt", 16'(sreq_cnt), 16'd0);
    check_eq("idle_cfg_cnt", 16'(cfg_cnt), 16'd0);

    // Write transfer
    bus_start();
    check_eq("wr_busy", 16'(bus_if.busy), 16'd1);
    write_byte(8'h50, ack);
    check_eq("wr_addr_ack", 16'(ack), 16'd1);
    exp_cfg_q.push_back(8'h10);
    write_byte(8'h10, ack);
    check_eq("wr_data_ack", 16'(ack), 16'd1);
    bus_stop();
    check_eq("wr_busy_after_stop", 16'(bus_if.busy), 16'd0);
    check_eq("wr_cfg_cnt", 16'(cfg_cnt), 16'd1);
    check_eq("wr_config_reg", 16'(bus_if.config_reg), 16'h10);

    // Read transfer, master NACKs the low byte
    bus_if.sample_data = 12'hA5C;
    bus_if.sample_channel = 2'b10;
    s0 = sreq_cnt;
    push_read(2'b10, 12'hA5C);
    bus_start();
    write_byte(8'h51, ack);
    check_eq("rd_addr_ack", 16'(ack), 16'd1);
    read_and_check(1'b0, "rd_hi");
    read_and_check(1'b1, "rd_lo");
    check_eq("rd_released_after_nack", 16'(bus_if.sda_oe), 16'd0);
    bus_stop();
    check_eq("rd_sreq_pulses", 16'(sreq_cnt - s0), 16'd1);
    check_eq("rd_busy_after_stop", 16'(bus_if.busy), 16'd0);

    // Wrong address, then repeated START to the right one
    s0 = sreq_cnt; c0 = cfg_cnt; o0 = oe_cycles;
    bus_start();
    write_byte(8'h52, ack);
    check_eq("wa_no_ack", 16'(ack), 16'd0);
    write_byte(8'h10, ack);
    check_eq("wa_data_no_ack", 16'(ack), 16'd0);
    check_eq("wa_oe_cycles", 16'(oe_cycles - o0), 16'd0);
    check_eq("wa_cfg_cnt", 16'(cfg_cnt - c0), 16'd0);
    check_eq("wa_sreq_cnt", 16'(sreq_cnt - s0), 16'd0);
    push_read(2'b10, 12'hA5C);
    bus_start();
    write_byte(8'h51, ack);
    check_eq("wa_then_addr_ack", 16'(ack), 16'd1);
    read_and_check(1'b0, "wa_rd_hi");
    read_and_check(1'b1, "wa_rd_lo");
    bus_stop();

    // Continuous read across two samples
    bus_if.sample_data = 12'h123;
    bus_if.sample_channel = 2'b00;
    s0 = sreq_cnt;
    push_read(2'b00, 12'h123);
    push_read(2'b00, 12'h456);
    bus_start();
    write_byte(8'h51, ack);
    check_eq("cr_addr_ack", 16'(ack), 16'd1);
    read_and_check(1'b0, "cr_hi0");
    bus_if.sample_data = 12'h456;
    read_and_check(1'b0, "cr_lo0");
    read_and_check(1'b0, "cr_hi1");
    read_and_check(1'b1, "cr_lo1");
    bus_stop();
    check_eq("cr_sreq_pulses", 16'(sreq_cnt - s0), 16'd2);

    // Repeated START four bits into a read byte
    bus_if.sample_data = 12'hA5C;
    bus_if.sample_channel = 2'b10;
    s0 = sreq_cnt;
    bus_start();
    write_byte(8'h51, ack);
    check_eq("rs_addr_ack", 16'(ack), 16'd1);
    read_bits(4, bits);
    check_eq("rs_partial_bits", 16'(bits), 16'h02);
    bus_start();
    check_eq("rs_sda_released", 16'(bus_if.sda_oe), 16'd0);
    check_eq("rs_busy", 16'(bus_if.busy), 16'd1);
    exp_cfg_q.push_back(8'h3C);
    write_byte(8'h50, ack);
    check_eq("rs_new_addr_ack", 16'(ack), 16'd1);
    write_byte(8'h3C, ack);
    check_eq("rs_data_ack", 16'(ack), 16'd1);
    bus_stop();
    check_eq("rs_sreq_pulses", 16'(sreq_cnt - s0), 16'd1);
    check_eq("rs_config_reg", 16'(bus_if.config_reg), 16'h3C);

    // Reset while the target drives the high byte
    bus_start();
    write_byte(8'h51, ack);
    check_eq("mr_addr_ack", 16'(ack), 16'd1);
    check_eq("mr_msb_driven", 16'(bus_if.sda_oe), 16'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_sda_released", 16'(bus_if.sda_oe), 16'd0);
    check_eq("mr_busy", 16'(bus_if.busy), 16'd0);
    check_eq("mr_config_reg", 16'(bus_if.config_reg), 16'h00);
    @(negedge clk);
    rst = 1'b1;
    o0 = oe_cycles;
    read_bits(8, bits);
    send_bit(1'b1);
    check_eq("mr_bus_ignored", 16'(bits), 16'hFF);
    check_eq("mr_oe_cycles", 16'(oe_cycles - o0), 16'd0);
    bus_stop();
    push_read(2'b10, 12'hA5C);
    bus_start();
    write_byte(8'h51, ack);
    check_eq("mr_fresh_addr_ack", 16'(ack), 16'd1);
    read_and_check(1'b0, "mr_rd_hi");
    read_and_check(1'b1, "mr_rd_lo");
    bus_stop();

    wait_q(2);
    check_eq("sda_stable_scl_high", 16'(sda_viol), 16'd0);
    check_eq("rd_q_drained", 16'(exp_rd_q.size()), 16'd0);
    check_eq("cfg_q_drained", 16'(exp_cfg_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
